// File: rtl/axi_mem_responder.sv
// AXI4 responder over a flip-flop word array, one transaction at a time.
// Optional error responses (DECERR/SLVERR) are enabled by defining AXI_MEM_ERR_EN.

package ariane_axi;
  localparam int unsigned ID_W = 4;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
    logic [3:0]      region;
    logic [5:0]      atop;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
    logic [3:0]      region;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_slv_t;

  localparam int unsigned REQ_W  = $bits(req_slv_t);
  localparam int unsigned RESP_W = $bits(resp_slv_t);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

module axi_mem_responder #(
  parameter int unsigned NUM_WORDS = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ariane_axi::REQ_W-1:0]  axi_req_i,
  output logic [ariane_axi::RESP_W-1:0] axi_resp_o
);

  localparam int unsigned IW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_READ       = 2'd1,
    S_WRITE      = 2'd2,
    S_WRITE_RESP = 2'd3
  } state_e;

  ariane_axi::req_slv_t  w_req;
  ariane_axi::resp_slv_t w_resp;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic                        r_prio_wr;
  logic [ariane_axi::ID_W-1:0] r_id;
  logic [IW-1:0]               r_idx;
  logic [7:0]                  r_len;
  logic [1:0]                  r_burst;
  logic [8:0]                  r_cnt;
  logic [1:0]                  r_resp;
  logic                        r_oor;
  logic [63:0]                 r_mem [NUM_WORDS];

  logic w_grant_rd, w_grant_wr;
  logic w_ar_ready, w_aw_ready, w_w_ready, w_r_valid, w_b_valid;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
  logic w_r_last;
  logic w_rd_oor, w_wr_oor, w_len_err;
  logic [1:0] w_rd_err, w_wr_err;
  logic w_unused_bits;

  function automatic logic [63:0] merge_strb(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_word;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] burst);
    if (burst == ariane_axi::BURST_FIXED) begin
      return idx;
    end
    return idx + IW'(1);
  endfunction

`ifdef AXI_MEM_ERR_EN
  function automatic logic addr_in_range(input logic [63:0] addr);
    return (addr >> (IW + 3)) == 64'd0;
  endfunction
`endif

  assign w_req         = ariane_axi::req_slv_t'(axi_req_i);
  assign axi_resp_o    = w_resp;
  assign w_unused_bits = ^{w_req.aw, w_req.ar};

  // Reset masks every handshake so nothing is accepted or issued while rst_i is high.
  assign w_grant_rd = w_req.ar_valid && (!w_req.aw_valid || !r_prio_wr);
  assign w_grant_wr = w_req.aw_valid && (!w_req.ar_valid || r_prio_wr);
  assign w_ar_ready = !rst_i && (r_state == S_IDLE) && w_grant_rd;
  assign w_aw_ready = !rst_i && (r_state == S_IDLE) && w_grant_wr;
  assign w_r_valid  = !rst_i && (r_state == S_READ);
  assign w_w_ready  = !rst_i && (r_state == S_WRITE);
  assign w_b_valid  = !rst_i && (r_state == S_WRITE_RESP);

  assign w_ar_hs  = w_ar_ready && w_req.ar_valid;
  assign w_aw_hs  = w_aw_ready && w_req.aw_valid;
  assign w_w_hs   = w_w_ready && w_req.w_valid;
  assign w_r_hs   = w_r_valid && w_req.r_ready;
  assign w_b_hs   = w_b_valid && w_req.b_ready;
  assign w_r_last = (r_cnt == {1'b0, r_len});

  // Error classification of the address phase and of the final write beat count.
  always_comb begin
    w_rd_oor  = 1'b0;
    w_wr_oor  = 1'b0;
    w_rd_err  = ariane_axi::RESP_OKAY;
    w_wr_err  = ariane_axi::RESP_OKAY;
    w_len_err = 1'b0;
`ifdef AXI_MEM_ERR_EN
    w_rd_oor  = !addr_in_range(w_req.ar.addr);
    w_wr_oor  = !addr_in_range(w_req.aw.addr);
    w_len_err = (r_cnt != {1'b0, r_len});
    if (w_rd_oor) begin
      w_rd_err = ariane_axi::RESP_DECERR;
    end else if (w_req.ar.burst == ariane_axi::BURST_WRAP) begin
      w_rd_err = ariane_axi::RESP_SLVERR;
    end else begin
      w_rd_err = ariane_axi::RESP_OKAY;
    end
    if (w_wr_oor) begin
      w_wr_err = ariane_axi::RESP_DECERR;
    end else if ((w_req.aw.burst == ariane_axi::BURST_WRAP) || (w_req.aw.atop != 6'd0)) begin
      w_wr_err = ariane_axi::RESP_SLVERR;
    end else begin
      w_wr_err = ariane_axi::RESP_OKAY;
    end
`endif
  end

  // Response struct: handshake flags plus payloads that are zero unless valid.
  always_comb begin
    w_resp          = '0;
    w_resp.aw_ready = w_aw_ready;
    w_resp.ar_ready = w_ar_ready;
    w_resp.w_ready  = w_w_ready;
    w_resp.b_valid  = w_b_valid;
    w_resp.r_valid  = w_r_valid;
    if (w_b_valid) begin
      w_resp.b.id   = r_id;
      w_resp.b.resp = r_resp;
    end else begin
      w_resp.b = '0;
    end
    if (w_r_valid) begin
      w_resp.r.id   = r_id;
      w_resp.r.data = r_oor ? 64'd0 : r_mem[r_idx];
      w_resp.r.resp = r_resp;
      w_resp.r.last = w_r_last;
    end else begin
      w_resp.r = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ar_hs) begin
          w_state_nxt = S_READ;
        end else if (w_aw_hs) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_r_hs && w_r_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (w_w_hs && w_req.w.last) begin
          w_state_nxt = S_WRITE_RESP;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE_RESP: begin
        if (w_b_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transaction context, beat counter, accumulated status and arbitration flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio_wr <= 1'b0;
      r_id      <= '0;
      r_idx     <= '0;
      r_len     <= 8'd0;
      r_burst   <= 2'b00;
      r_cnt     <= 9'd0;
      r_resp    <= 2'b00;
      r_oor     <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= w_req.ar.id;
      r_idx   <= w_req.ar.addr[IW+2:3];
      r_len   <= w_req.ar.len;
      r_burst <= w_req.ar.burst;
      r_cnt   <= 9'd0;
      r_resp  <= w_rd_err;
      r_oor   <= w_rd_oor;
    end else if (w_aw_hs) begin
      r_id    <= w_req.aw.id;
      r_idx   <= w_req.aw.addr[IW+2:3];
      r_len   <= w_req.aw.len;
      r_burst <= w_req.aw.burst;
      r_cnt   <= 9'd0;
      r_resp  <= w_wr_err;
      r_oor   <= w_wr_oor;
    end else if (w_r_hs) begin
      r_cnt <= r_cnt + 9'd1;
      r_idx <= next_idx(r_idx, r_burst);
      if (w_r_last) begin
        r_prio_wr <= 1'b1;
      end
    end else if (w_w_hs) begin
      // Saturate so an overlong burst can never alias back to a matching count.
      if (r_cnt != 9'h1FF) begin
        r_cnt <= r_cnt + 9'd1;
      end
      r_idx <= next_idx(r_idx, r_burst);
      if (w_req.w.last && (r_resp == ariane_axi::RESP_OKAY) && w_len_err) begin
        r_resp <= ariane_axi::RESP_SLVERR;
      end
    end else if (w_b_hs) begin
      r_prio_wr <= 1'b0;
    end
  end

  // Byte-strobed memory write; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_w_hs && !r_oor) begin
      r_mem[r_idx] <= merge_strb(r_mem[r_idx], w_req.w.data, w_req.w.strb);
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed scenarios plus randomized
// write/read traffic checked against a word-array model.

module tb_axi_mem_responder;
  localparam int N = 256;

  logic clk;
  logic rst_i;
  ariane_axi::req_slv_t  req;
  ariane_axi::resp_slv_t resp;
  logic [ariane_axi::REQ_W-1:0]  req_v;
  logic [ariane_axi::RESP_W-1:0] resp_v;

  assign req_v = req;
  assign resp  = ariane_axi::resp_slv_t'(resp_v);

  axi_mem_responder #(.NUM_WORDS(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .axi_req_i  (req_v),
    .axi_resp_o (resp_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] model   [N];
  logic [63:0] wbuf    [256];
  logic [7:0]  sbuf    [256];
  logic [63:0] rd_data [256];
  logic        rd_last [256];
  logic [3:0]  rd_id   [256];
  logic [1:0]  rd_resp [256];

  function automatic void model_write(input int base, input int nbeats, input logic [1:0] burst);
    int idx;
    for (int b = 0; b < nbeats; b++) begin
      idx = (burst == 2'b00) ? base : (base + b) % N;
      for (int k = 0; k < 8; k++) begin
        if (sbuf[b][k]) model[idx][8*k +: 8] = wbuf[b][8*k +: 8];
      end
    end
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats,
                           output logic [1:0] bresp, output logic [3:0] bid,
                           output int ok, output int wlat, output int blat);
    int t;
    ok = 0; bresp = 2'b01; bid = 4'd0; wlat = 0; blat = 0;
    req.aw = '0;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.burst = burst; req.aw.size = 3'd3;
    req.aw_valid = 1'b1;
    #1;
    t = 0;
    while (!resp.aw_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!resp.aw_ready) begin req.aw_valid = 1'b0; return; end
    @(negedge clk);
    req.aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      req.w.data = wbuf[b]; req.w.strb = sbuf[b]; req.w.last = (b == nbeats - 1);
      req.w_valid = 1'b1;
      #1;
      if (b == 0) wlat = resp.w_ready ? 1 : 0;
      t = 0;
      while (!resp.w_ready && t < 50) begin @(negedge clk); #1; t++; end
      if (!resp.w_ready) begin req.w_valid = 1'b0; return; end
      @(negedge clk);
    end
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    #1;
    blat = resp.b_valid ? 1 : 0;
    t = 0;
    while (!resp.b_valid && t < 50) begin @(negedge clk); #1; t++; end
    if (resp.b_valid) begin ok = 1; bresp = resp.b.resp; bid = resp.b.id; end
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat,
                          output int got, output int rlat, output int gaps, output int unstable);
    int t;
    logic seen_last;
    ariane_axi::r_chan_t snap;
    got = 0; rlat = 0; gaps = 0; unstable = 0; seen_last = 1'b0;
    req.ar = '0;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.burst = burst; req.ar.size = 3'd3;
    req.ar_valid = 1'b1;
    #1;
    t = 0;
    while (!resp.ar_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!resp.ar_ready) begin req.ar_valid = 1'b0; return; end
    @(negedge clk);
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    #1;
    rlat = resp.r_valid ? 1 : 0;
    t = 0;
    while (!seen_last && got < 256 && t < 600) begin
      if (resp.r_valid) begin
        if (got == stall_beat) begin
          snap = resp.r; req.r_ready = 1'b0;
          repeat (5) begin
            @(negedge clk); #1;
            if (!resp.r_valid || resp.r !== snap) unstable++;
          end
          req.r_ready = 1'b1;
          #1;
        end
        rd_data[got] = resp.r.data; rd_last[got] = resp.r.last;
        rd_id[got] = resp.r.id; rd_resp[got] = resp.r.resp;
        seen_last = resp.r.last;
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      @(negedge clk); #1; t++;
    end
    req.r_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req.ar_valid = 1'b1; req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1; req.r_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (resp_v !== '0) begin bad++; $display("FAIL reset_during_rst got=%h want=0", resp_v); end
    req = '0;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    total++;
    if (resp_v !== '0) begin bad++; $display("FAIL reset_idle_outputs got=%h want=0", resp_v); end
    @(negedge clk);
  endtask

  task automatic test_fill;
    logic [1:0] br; logic [3:0] bi; int ok, wl, bl;
    for (int i = 0; i < N; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(4'd1, 64'd0, 8'(N - 1), 2'b01, N, br, bi, ok, wl, bl);
    model_write(0, N, 2'b01);
    total++;
    if (ok != 1 || br !== 2'b00 || bi !== 4'd1) begin
      bad++; $display("FAIL fill_write ok=%0d resp=%0h id=%0h want ok=1 resp=0 id=1", ok, br, bi);
    end
  endtask

  task automatic test_single;
    logic [1:0] br; logic [3:0] bi; int ok, wl, bl, got, rl, gp, us;
    wbuf[0] = 64'hDEADBEEF_01234567; sbuf[0] = 8'hFF;
    axi_write(4'd5, 64'h10, 8'd0, 2'b01, 1, br, bi, ok, wl, bl);
    model_write(2, 1, 2'b01);
    total++;
    if (ok != 1 || br !== 2'b00 || bi !== 4'd5) begin
      bad++; $display("FAIL single_b ok=%0d resp=%0h id=%0h want 1/0/5", ok, br, bi);
    end
    total++;
    if (wl != 1 || bl != 1) begin bad++; $display("FAIL single_wlat wlat=%0d blat=%0d want 1/1", wl, bl); end
    axi_read(4'd3, 64'h10, 8'd0, 2'b01, -1, got, rl, gp, us);
    total++;
    if (got != 1 || rd_data[0] !== 64'hDEADBEEF_01234567 || rd_last[0] !== 1'b1 || rd_id[0] !== 4'd3 || rd_resp[0] !== 2'b00) begin
      bad++; $display("FAIL single_r beats=%0d data=%h last=%b id=%h resp=%h want 1 deadbeef01234567 1 3 0",
                      got, rd_data[0], rd_last[0], rd_id[0], rd_resp[0]);
    end
    total++;
    if (rl != 1) begin bad++; $display("FAIL single_rlat got=%0d want=1", rl); end
  endtask

  task automatic test_incr_fixed;
    logic [1:0] br; logic [3:0] bi; int ok, wl, bl, got, rl, gp, us;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
    axi_write(4'd2, 64'h0, 8'd3, 2'b01, 4, br, bi, ok, wl, bl);
    model_write(0, 4, 2'b01);
    total++;
    if (ok != 1 || br !== 2'b00 || bi !== 4'd2) begin
      bad++; $display("FAIL incr_b ok=%0d resp=%0h id=%0h want 1/0/2", ok, br, bi);
    end
    axi_read(4'd4, 64'h0, 8'd3, 2'b01, -1, got, rl, gp, us);
    total++;
    if (got != 4 || gp != 0 || rl != 1) begin bad++; $display("FAIL incr_r_shape beats=%0d gaps=%0d rlat=%0d want 4/0/1", got, gp, rl); end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (rd_data[b] !== 64'(b + 1) || rd_last[b] !== (b == 3)) begin
        bad++; $display("FAIL incr_r_beat%0d data=%h last=%b want %h %b", b, rd_data[b], rd_last[b], 64'(b + 1), (b == 3));
      end
    end
    axi_read(4'd4, 64'h0, 8'd1, 2'b00, -1, got, rl, gp, us);
    total++;
    if (got != 2 || rd_data[0] !== 64'd1 || rd_data[1] !== 64'd1 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      bad++; $display("FAIL fixed_r beats=%0d d0=%h d1=%h want 2 beats of 1", got, rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] br; logic [3:0] bi; int ok, wl, bl, got, rl, gp, us;
    wbuf[0] = 64'hFFFFFFFF_FFFFFFFF; sbuf[0] = 8'h0F;
    axi_write(4'd7, 64'h0, 8'd0, 2'b01, 1, br, bi, ok, wl, bl);
    model_write(0, 1, 2'b01);
    axi_read(4'd7, 64'h0, 8'd0, 2'b01, -1, got, rl, gp, us);
    total++;
    if (got != 1 || rd_data[0] !== 64'h00000000_FFFFFFFF) begin
      bad++; $display("FAIL strobe_readback data=%h want 00000000ffffffff", rd_data[0]);
    end
  endtask

  task automatic test_arbitration;
    logic [63:0] d;
    d = {$urandom, $urandom};
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    req.ar = '0; req.ar.id = 4'd1; req.ar.addr = 64'h10; req.ar.burst = 2'b01; req.ar_valid = 1'b1;
    req.aw = '0; req.aw.id = 4'd2; req.aw.addr = 64'h18; req.aw.burst = 2'b01; req.aw_valid = 1'b1;
    #1;
    total++;
    if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b0) begin
      bad++; $display("FAIL arb_first ar_ready=%b aw_ready=%b want 1/0", resp.ar_ready, resp.aw_ready);
    end
    @(negedge clk);
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    #1;
    total++;
    if (resp.r_valid !== 1'b1 || resp.r.data !== model[2] || resp.r.id !== 4'd1 || resp.aw_ready !== 1'b0) begin
      bad++; $display("FAIL arb_read r_valid=%b data=%h id=%h aw_ready=%b want 1 %h 1 0", resp.r_valid, resp.r.data, resp.r.id, resp.aw_ready, model[2]);
    end
    @(negedge clk);
    req.r_ready = 1'b0;
    req.ar.id = 4'd4; req.ar.addr = 64'h18; req.ar_valid = 1'b1;
    #1;
    total++;
    if (resp.aw_ready !== 1'b1 || resp.ar_ready !== 1'b0) begin
      bad++; $display("FAIL arb_write_next ar_ready=%b aw_ready=%b want 0/1", resp.ar_ready, resp.aw_ready);
    end
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w.data = d; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
    #1;
    total++;
    if (resp.w_ready !== 1'b1 || resp.ar_ready !== 1'b0) begin
      bad++; $display("FAIL arb_wbeat w_ready=%b ar_ready=%b want 1/0", resp.w_ready, resp.ar_ready);
    end
    @(negedge clk);
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    wbuf[0] = d; sbuf[0] = 8'hFF; model_write(3, 1, 2'b01);
    #1;
    total++;
    if (resp.b_valid !== 1'b1 || resp.b.id !== 4'd2 || resp.b.resp !== 2'b00) begin
      bad++; $display("FAIL arb_b b_valid=%b id=%h resp=%h want 1 2 0", resp.b_valid, resp.b.id, resp.b.resp);
    end
    @(negedge clk);
    req.b_ready = 1'b0;
    req.aw.id = 4'd6; req.aw.addr = 64'h20; req.aw_valid = 1'b1;
    #1;
    total++;
    if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b0) begin
      bad++; $display("FAIL arb_read_again ar_ready=%b aw_ready=%b want 1/0", resp.ar_ready, resp.aw_ready);
    end
    @(negedge clk);
    req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.r_ready = 1'b1;
    #1;
    total++;
    if (resp.r_valid !== 1'b1 || resp.r.data !== model[3] || resp.r.id !== 4'd4) begin
      bad++; $display("FAIL arb_read2 r_valid=%b data=%h id=%h want 1 %h 4", resp.r_valid, resp.r.data, resp.r.id, model[3]);
    end
    @(negedge clk);
    req.r_ready = 1'b0;
  endtask

  task automatic test_stall;
    int got, rl, gp, us;
    axi_read(4'd9, 64'h0, 8'd3, 2'b01, 1, got, rl, gp, us);
    total++;
    if (got != 4 || us != 0) begin bad++; $display("FAIL stall_shape beats=%0d unstable=%0d want 4/0", got, us); end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (rd_data[b] !== model[b] || rd_id[b] !== 4'd9 || rd_last[b] !== (b == 3)) begin
        bad++; $display("FAIL stall_beat%0d data=%h id=%h last=%b want %h 9 %b", b, rd_data[b], rd_id[b], rd_last[b], model[b], (b == 3));
      end
    end
  endtask

  task automatic test_out_of_range;
    int got, rl, gp, us;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
`ifdef AXI_MEM_ERR_EN
    exp_d = 64'd0;    exp_r = 2'b11;
`else
    exp_d = model[0]; exp_r = 2'b00;
`endif
    axi_read(4'd8, 64'(N * 8), 8'd0, 2'b01, -1, got, rl, gp, us);
    total++;
    if (got != 1 || rd_data[0] !== exp_d || rd_resp[0] !== exp_r) begin
      bad++; $display("FAIL oor_read beats=%0d data=%h resp=%h want 1 %h %h", got, rd_data[0], rd_resp[0], exp_d, exp_r);
    end
  endtask

  task automatic test_reset_midburst;
    int t, bseen, got, rl, gp, us;
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    req.aw = '0; req.aw.id = 4'hA; req.aw.addr = 64'h40; req.aw.len = 8'd3; req.aw.burst = 2'b01;
    req.aw_valid = 1'b1;
    #1;
    t = 0;
    while (!resp.aw_ready && t < 50) begin @(negedge clk); #1; t++; end
    @(negedge clk);
    req.aw_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      req.w.data = wbuf[b]; req.w.strb = 8'hFF; req.w.last = 1'b0; req.w_valid = 1'b1;
      #1;
      total++;
      if (resp.w_ready !== 1'b1) begin bad++; $display("FAIL midrst_wready%0d got=%b want=1", b, resp.w_ready); end
      @(negedge clk);
    end
    req.w.data = wbuf[2]; rst_i = 1'b1;
    #1;
    total++;
    if (resp.w_ready !== 1'b0) begin bad++; $display("FAIL midrst_wready_in_rst got=%b want=0", resp.w_ready); end
    @(negedge clk);
    rst_i = 1'b0; req.w_valid = 1'b0; req.b_ready = 1'b1;
    bseen = 0;
    repeat (3) begin #1; if (resp.b_valid !== 1'b0) bseen++; @(negedge clk); end
    req.b_ready = 1'b0;
    total++;
    if (bseen != 0) begin bad++; $display("FAIL midrst_no_b b_valid_cycles=%0d want=0", bseen); end
    model_write(8, 2, 2'b01);
    axi_read(4'd3, 64'h40, 8'd2, 2'b01, -1, got, rl, gp, us);
    total++;
    if (got != 3 || rd_data[0] !== model[8] || rd_data[1] !== model[9] || rd_data[2] !== model[10]) begin
      bad++; $display("FAIL midrst_readback beats=%0d d=%h %h %h want %h %h %h", got, rd_data[0], rd_data[1], rd_data[2], model[8], model[9], model[10]);
    end
  endtask

  task automatic test_random;
    logic [1:0] br; logic [3:0] bi, id; logic [1:0] bu, rbu;
    int ok, wl, bl, got, rl, gp, us, base, len, rbase, rlen, idx;
    for (int it = 0; it < 20; it++) begin
      id = 4'($urandom_range(15, 0)); base = $urandom_range(N - 1, 0); len = $urandom_range(7, 0);
      bu = ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b00;
      for (int b = 0; b <= len; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'($urandom_range(255, 0)); end
      axi_write(id, 64'(base * 8 + $urandom_range(7, 0)), 8'(len), bu, len + 1, br, bi, ok, wl, bl);
      model_write(base, len + 1, bu);
      total++;
      if (ok != 1 || br !== 2'b00 || bi !== id) begin
        bad++; $display("FAIL rnd_b it=%0d ok=%0d resp=%h id=%h want 1 0 %h", it, ok, br, bi, id);
      end
      rbase = (base + $urandom_range(3, 0)) % N; rlen = $urandom_range(7, 0);
      rbu = ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b00;
      axi_read(~id, 64'(rbase * 8), 8'(rlen), rbu, -1, got, rl, gp, us);
      total++;
      if (got != rlen + 1 || gp != 0) begin bad++; $display("FAIL rnd_r_shape it=%0d beats=%0d gaps=%0d want %0d 0", it, got, gp, rlen + 1); end
      for (int b = 0; b <= rlen; b++) begin
        idx = (rbu == 2'b00) ? rbase : (rbase + b) % N;
        total++;
        if (rd_data[b] !== model[idx] || rd_last[b] !== (b == rlen) || rd_id[b] !== ~id || rd_resp[b] !== 2'b00) begin
          bad++; $display("FAIL rnd_r it=%0d beat=%0d data=%h last=%b id=%h want %h %b %h", it, b, rd_data[b], rd_last[b], rd_id[b], model[idx], (b == rlen), ~id);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req   = '0;
    rst_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_fill();
    test_single();
    test_incr_fixed();
    test_strobe();
    test_arbitration();
    test_stall();
    test_out_of_range();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
